// File: rtl/mouse_frame_latch.sv
// mouse_frame_latch
//   Latches PS/2 mouse position/buttons into clamped shadow registers as the
//   controller reports them, and publishes them to the cursor stage only at
//   the rising edge of vertical blank so the cursor never tears mid-frame.
//   Also produces frame-aligned left click / release / long-press pulses.
//
// Ports
//   clk, rst            pixel clock; synchronous active-high reset
//   xpos_raw, ypos_raw  12-bit raw position from the mouse controller
//   left_raw, right_raw raw button levels
//   new_event           one-cycle strobe qualifying the raw inputs
//   vblnk               vertical blank from the timing stage
//   xpos, ypos          frame-stable clamped position
//   left_held,right_held frame-stable button levels
//   left_click, left_release, long_press  one-cycle frame-aligned pulses
//   frame_tick          one-cycle pulse at each publish point
module mouse_frame_latch #(
  parameter int unsigned H_ACTIVE          = 1024,
  parameter int unsigned V_ACTIVE          = 768,
  parameter int unsigned LONG_PRESS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        left_raw,
  input  logic        right_raw,
  input  logic        new_event,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_held,
  output logic        right_held,
  output logic        left_click,
  output logic        left_release,
  output logic        long_press,
  output logic        frame_tick
);

  localparam int unsigned CW       = $clog2(LONG_PRESS_FRAMES + 1);
  localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
  localparam logic [CW-1:0] CNT_LP = CW'(LONG_PRESS_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_e;

  // Shadow registers (clamped at load time)
  logic [11:0] sx_q, sy_q;
  logic        sl_q, sr_q;
  logic        vblnk_q;
  logic        frame_edge;

  // Published outputs
  logic [11:0] xpos_q, ypos_q;
  logic        left_q, right_q, tick_q;
  logic        click_q, release_q, long_q;
  logic        click_d, release_d, long_d;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign frame_edge = vblnk & ~vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q    <= '0;
      sy_q    <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      if (new_event) begin
        sx_q <= (xpos_raw > X_MAX) ? X_MAX : xpos_raw;
        sy_q <= (ypos_raw > Y_MAX) ? Y_MAX : ypos_raw;
        sl_q <= left_raw;
        sr_q <= right_raw;
      end
    end
  end

  // Publishing reads the shadow before this cycle's strobe lands, so a
  // strobe coincident with the edge is deferred to the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q    <= '0;
      ypos_q    <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      tick_q    <= 1'b0;
      click_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      tick_q    <= frame_edge;
      click_q   <= click_d;
      release_q <= release_d;
      long_q    <= long_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (frame_edge) begin
        xpos_q  <= sx_q;
        ypos_q  <= sy_q;
        left_q  <= sl_q;
        right_q <= sr_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    click_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    if (frame_edge) begin
      unique case (state_q)
        IDLE: begin
          if (sl_q) begin
            state_d = PRESSED;
            cnt_d   = CW'(1);
            click_d = 1'b1;
          end
        end
        PRESSED: begin
          if (!sl_q) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q + CW'(1) == CNT_LP) begin
            state_d = LONG;
            cnt_d   = CNT_LP;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LONG: begin
          if (!sl_q) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign left_held    = left_q;
  assign right_held   = right_q;
  assign frame_tick   = tick_q;
  assign left_click   = click_q;
  assign left_release = release_q;
  assign long_press   = long_q;

endmodule

// File: tb/tb_mouse_frame_latch.sv
module tb_mouse_frame_latch;

  localparam int LPF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_raw = '0, ypos_raw = '0;
  logic        left_raw = 1'b0, right_raw = 1'b0, new_event = 1'b0, vblnk = 1'b0;
  logic [11:0] xpos, ypos;
  logic        left_held, right_held, left_click, left_release, long_press, frame_tick;

  mouse_frame_latch #(.H_ACTIVE(1024), .V_ACTIVE(768), .LONG_PRESS_FRAMES(LPF)) dut (
    .clk(clk), .rst(rst), .xpos_raw(xpos_raw), .ypos_raw(ypos_raw),
    .left_raw(left_raw), .right_raw(right_raw), .new_event(new_event), .vblnk(vblnk),
    .xpos(xpos), .ypos(ypos), .left_held(left_held), .right_held(right_held),
    .left_click(left_click), .left_release(left_release), .long_press(long_press),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, l, r, click, rel, lng;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: what the mouse last reported, and how many
  // consecutive published frames the left button has been down.
  int sh_x = 0, sh_y = 0, sh_l = 0, sh_r = 0;
  int prev_vb = 0;
  int held_frames = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock cycle of stimulus; the model predicts before the edge.
  task automatic step(input bit ne, input int x, input int y, input bit l, input bit r, input bit vb);
    exp_t e;
    if (vb && !prev_vb) begin
      e.x = sh_x; e.y = sh_y; e.l = sh_l; e.r = sh_r;
      e.click = 0; e.rel = 0; e.lng = 0;
      if (sh_l != 0) begin
        if (held_frames <= LPF) held_frames++;
        e.click = (held_frames == 1) ? 1 : 0;
        e.lng   = (held_frames == LPF) ? 1 : 0;
      end else begin
        e.rel = (held_frames > 0) ? 1 : 0;
        held_frames = 0;
      end
      exp_q.push_back(e);
    end
    if (ne) begin
      sh_x = imin(x, 1023);
      sh_y = imin(y, 767);
      sh_l = l;
      sh_r = r;
    end
    prev_vb = vb;
    new_event = ne; xpos_raw = 12'(x); ypos_raw = 12'(y);
    left_raw = l; right_raw = r; vblnk = vb;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    new_event = 1'b0; vblnk = 1'b0;
    sh_x = 0; sh_y = 0; sh_l = 0; sh_r = 0;
    prev_vb = 0; held_frames = 0;
    exp_q.delete();
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // A frame boundary: a few low cycles, then vblnk high for hi cycles.
  task automatic frame(input int hi);
    idle(3);
    for (int i = 0; i < hi; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic event_(input int x, input int y, input bit l, input bit r);
    step(1'b1, x, y, l, r, 1'b0);
  endtask

  // Monitor: pops on every frame_tick; between ticks outputs must hold.
  logic rst_s = 1'b1;
  bit   mon_en = 1'b0;
  int   cur_x = 0, cur_y = 0, cur_l = 0, cur_r = 0;
  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_s) begin
        chk("rst_xpos", int'(xpos), 0);
        chk("rst_ypos", int'(ypos), 0);
        chk("rst_flags", int'({left_held, right_held, left_click, left_release, long_press, frame_tick}), 0);
        cur_x = 0; cur_y = 0; cur_l = 0; cur_r = 0;
      end else if (frame_tick) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("xpos", int'(xpos), e.x);
          chk("ypos", int'(ypos), e.y);
          chk("left_held", int'(left_held), e.l);
          chk("right_held", int'(right_held), e.r);
          chk("left_click", int'(left_click), e.click);
          chk("left_release", int'(left_release), e.rel);
          chk("long_press", int'(long_press), e.lng);
          cur_x = e.x; cur_y = e.y; cur_l = e.l; cur_r = e.r;
        end
      end else begin
        chk("hold_xpos", int'(xpos), cur_x);
        chk("hold_ypos", int'(ypos), cur_y);
        chk("hold_buttons", int'({left_held, right_held}), cur_l * 2 + cur_r);
        chk("no_pulse", int'({left_click, left_release, long_press}), 0);
      end
    end
  end

  initial begin
    do_reset(3);
    mon_en = 1'b1;

    // Out of reset: single tick with zeros despite vblnk held long
    idle(4);
    frame(100);

    // Mid-frame update, then clamping
    event_(500, 300, 1'b0, 1'b1);
    idle(5);
    frame(3);
    event_(4000, 768, 1'b0, 1'b0);
    frame(3);
    event_(1023, 5, 1'b0, 1'b0);
    frame(3);

    // Strobe coincident with the edge is deferred one frame
    event_(20, 7, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 10, 8, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    frame(2);

    // Long press: 6 held frames, release, then a 2-frame press
    event_(100, 100, 1'b1, 1'b0);
    repeat (6) frame(2);
    event_(100, 100, 1'b0, 1'b0);
    frame(2);
    event_(101, 100, 1'b1, 1'b0);
    repeat (2) frame(2);
    event_(101, 100, 1'b0, 1'b0);
    repeat (2) frame(2);

    // Reset mid-press, then a fresh click
    event_(50, 60, 1'b1, 1'b0);
    repeat (2) frame(2);
    do_reset(2);
    idle(2);
    event_(50, 60, 1'b1, 1'b0);
    frame(2);
    frame(2);

    // Randomised traffic
    begin
      bit l = 1'b0, vb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        bit ne;
        ne = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 11) == 0) l = ~l;
        if ($urandom_range(0, 9) == 0) vb = ~vb;
        step(ne, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
             l, 1'($urandom_range(0, 1)), vb);
      end
    end

    idle(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
